// File: rtl/ncpu32k_tsc.sv
// Timestamp counter with prescaler and compare match. Drives a level IRQ
// that stays high until software clears the sticky pending bit in TCR.
module ncpu32k_tsc #(
  parameter int DW       = 32,
  parameter int CMP_DW   = 28,
  parameter int PRESC_DW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [DW-1:0]       msr_tsc_tsr,
  input  logic [DW-1:0]       msr_tsc_tsr_nxt,
  input  logic                msr_tsc_tsr_we,
  output logic [DW-1:0]       msr_tsc_tcr,
  input  logic [DW-1:0]       msr_tsc_tcr_nxt,
  input  logic                msr_tsc_tcr_we,
  output logic [PRESC_DW-1:0] msr_tsc_tps,
  input  logic [PRESC_DW-1:0] msr_tsc_tps_nxt,
  input  logic                msr_tsc_tps_we,
  output logic                tsc_irq
);

  localparam int EN_B = CMP_DW;
  localparam int I_B  = CMP_DW + 1;
  localparam int P_B  = CMP_DW + 2;
  localparam int M_B  = CMP_DW + 3;

  logic [DW-1:0]       tsr;
  logic [DW-1:0]       tcr;
  logic [PRESC_DW-1:0] tps;
  logic [PRESC_DW-1:0] pc;
  logic [DW-1:0]       inc;
  logic                tick;
  logic                match;
  logic                p_set;

  assign tick  = tcr[EN_B] & (pc == tps);
  assign inc   = tsr + {{(DW-1){1'b0}}, 1'b1};
  assign match = tick & ~msr_tsc_tsr_we & (inc[CMP_DW-1:0] == tcr[CMP_DW-1:0]);
  assign p_set = match & tcr[I_B];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= '0;
    else if (msr_tsc_tps_we || !tcr[EN_B] || tick)
      pc <= '0;
    else
      pc <= pc + {{(PRESC_DW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tsr <= '0;
    else if (msr_tsc_tsr_we)
      tsr <= msr_tsc_tsr_nxt;
    else if (tick)
      tsr <= (tcr[M_B] & match) ? '0 : inc;
  end

  // A hardware match beats a software clear of P in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tcr <= '0;
    else if (msr_tsc_tcr_we)
      tcr <= {msr_tsc_tcr_nxt[DW-1:P_B+1],
              msr_tsc_tcr_nxt[P_B] | p_set,
              msr_tsc_tcr_nxt[P_B-1:0]};
    else if (p_set)
      tcr[P_B] <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tps <= '0;
    else if (msr_tsc_tps_we)
      tps <= msr_tsc_tps_nxt;
  end

  assign msr_tsc_tsr = msr_tsc_tsr_we ? msr_tsc_tsr_nxt : tsr;
  assign msr_tsc_tcr = msr_tsc_tcr_we ? msr_tsc_tcr_nxt : tcr;
  assign msr_tsc_tps = msr_tsc_tps_we ? msr_tsc_tps_nxt : tps;
  assign tsc_irq     = tcr[P_B] & tcr[I_B];

endmodule

// File: doc/ncpu32k_tsc.md
Name: ncpu32k_tsc

Overview:
Timestamp counter and compare timer; the interrupt source that drives one level-triggered line into the IRQ controller's synchronised IRQ input vector.
- Software programs it through three MSRs: TSR (count), TCR (control/compare) and TPS (prescaler).
- It raises a level IRQ on compare match.
- The IRQ is held until software clears the pending bit.

Parameters:
- DW, 32, MSR data width.
- CMP_DW, 28, compare field width in TCR. Must equal DW-4.
- PRESC_DW, 8, prescaler register width.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- msr_tsc_tsr  output  DW  TSR read value, write-bypassed
- msr_tsc_tsr_nxt  input  DW  TSR write data
- msr_tsc_tsr_we  input  1  TSR write enable
- msr_tsc_tcr  output  DW  TCR read value, write-bypassed
- msr_tsc_tcr_nxt  input  DW  TCR write data
- msr_tsc_tcr_we  input  1  TCR write enable
- msr_tsc_tps  output  PRESC_DW  TPS read value, write-bypassed
- msr_tsc_tps_nxt  input  PRESC_DW  TPS write data
- msr_tsc_tps_we  input  1  TPS write enable
- tsc_irq  output  1  level IRQ to the IRQ controller input vector

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: TSR=0, TCR=0, TPS=0, prescaler counter=0, tsc_irq=0. Reset mid-count clears everything immediately (asynchronous).
- TCR layout:
  - [CMP_DW-1:0] CMP
  - [CMP_DW] EN (count enable)
  - [CMP_DW+1] I (interrupt enable)
  - [CMP_DW+2] P (pending, sticky)
  - [CMP_DW+3] M (auto-reload)
- Read bypass: each msr_tsc_* output returns *_nxt in a cycle where its *_we=1; otherwise it returns the register.
- Prescaler:
  - 8-bit counter pc.
  - EN=0: pc held at 0, no ticks.
  - EN=1: tick asserted when pc==TPS; pc then returns to 0, else pc increments.
  - TPS=0 gives a tick every cycle; TPS=N gives a tick every N+1 cycles.
  - A TPS write clears pc to 0 in the same edge.
- Count: on a tick, inc = TSR+1 (mod 2^DW).
  - match = (inc[CMP_DW-1:0]==CMP).
  - If M=1 and match: TSR<=0. Otherwise TSR<=inc.
  - With M=0, TSR wraps 0xFFFF_FFFF->0.
- TSR write:
  - msr_tsc_tsr_we loads tsr_nxt and overrides that cycle's tick.
  - No match is evaluated in a TSR write cycle.
  - pc is not affected.
- Pending:
  - On a match with I=1, P<=1.
  - A match with I=0 does not set P.
  - A TCR write loads CMP/EN/I/M and P from tcr_nxt.
  - If a hardware match-set and a software write of P=0 occur in the same cycle, the set wins (P=1); an event is never lost.
  - Software may also set P by writing 1.
- IRQ: tsc_irq = P & I, taken from registered bits only (glitch-free, safe for the controller's synchroniser). Zero extra latency from P.
- Latency: the match is detected on the tick edge. P and tsc_irq are high the cycle after the edge where TSR takes the matching value.
- Simultaneous TCR write clearing EN and a tick: the tick of that cycle still applies, using the old EN. Counting stops from the next cycle.

Test Plan:
- TPS=0; TCR: CMP=5, EN=1, I=1; TSR=0 -> TSR reads 1,2,3,4,5 on successive cycles; P=1 and tsc_irq=1 with TSR=5; irq stays 1 for 20 cycles; TCR write P=0 -> irq 0 next cycle.
- TPS=3, EN=1, TSR=0 -> TSR increments every 4 cycles (0 for 4 cycles, then 1, ...); a TPS write mid-period restarts the 4-cycle spacing.
- M=1, CMP=2, I=1 -> TSR sequence 0,1,0,1,...; P set on the first 1->0 reload; clear P -> set again on the next reload.
- Matching tick in the same cycle as a TCR write with P=0 -> P reads 1 afterwards, tsc_irq=1.
- TSR written 0xFFFF_FFFF, CMP=0, M=0, I=1, TPS=0 -> next TSR=0, P=1. Repeat with I=0 -> TSR=0, P=0, irq 0.
- rst_n pulsed low asynchronously mid-count with irq high -> TSR/TCR/TPS read 0 and tsc_irq=0 before the next clk edge; no counting after release until EN is written 1.
